rvfi_retire_serializer: RTL
===========================

Name: rvfi_retire_serializer

Overview:
- Collects retirements from all NRET RVFI channels and replays them one per cycle, in program order, on a single-channel ready/valid stream.
- Lets one single-channel checker instance (imem, pc-forward, insn checks) be time-shared across all retire channels instead of being replicated per channel.
- Sits between the core's RVFI bus and the downstream checkers in the formal wrapper.
- Also flags FIFO overflow and retire-order discontinuities.

Parameters:
- NRET, 2, number of retire channels (>=1)
- XLEN, 32, register/PC width
- ILEN, 32, instruction width
- ORDW, 8, width of one rvfi_order field
- DEPTH, 8, FIFO entries; power of two, DEPTH >= NRET

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- rvfi_valid  in  NRET  per-channel retire valid
- rvfi_order  in  NRET*ORDW  per-channel retire order
- rvfi_insn  in  NRET*ILEN  per-channel instruction word
- rvfi_pc_rdata  in  NRET*XLEN  per-channel PC before execution
- rvfi_pc_wdata  in  NRET*XLEN  per-channel next PC
- rvfi_trap  in  NRET  per-channel trap
- rvfi_halt  in  NRET  per-channel halt
- rvfi_intr  in  NRET  per-channel interrupt
- out_valid  out  1  output record available
- out_ready  in  1  consumer accepts record
- out_order  out  ORDW  record order
- out_insn  out  ILEN  record instruction
- out_pc_rdata  out  XLEN  record PC before execution
- out_pc_wdata  out  XLEN  record next PC
- out_trap, out_halt, out_intr  out  1 each  record flags
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a retire group was dropped
- order_err  out  1  sticky: order discontinuity at output

Behaviour:
- Record: {order, insn, pc_rdata, pc_wdata, trap, halt, intr}, stored in a circular FIFO with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Reset (resetn=0 at posedge): wr_ptr=rd_ptr=0, level=0, out_valid=0, overflow=0, order_err=0, expect_valid=0. Reset mid-stream discards all contents; inputs are ignored in the reset cycle.
- Pop: when out_valid && out_ready, rd_ptr+1 and level-1.
- Push group: when resetn=1, k = popcount(rvfi_valid).
  - Free space for the cycle = DEPTH - level + pop (a same-cycle pop frees its slot first).
  - If k <= free: write the valid channels in ascending channel index, compacted into consecutive slots from wr_ptr; wr_ptr += k; level += k - pop.
  - If k > free: drop the whole group (no partial write), set overflow=1; the pop still occurs.
- Output is registered FIFO head, zero-latency from storage:
  - out_valid = (level != 0).
  - out_* = entry[rd_ptr].
  - A record pushed in cycle N is first visible at cycle N+1 (no bypass).
  - Outputs are stable while out_valid && !out_ready.
- Order checker:
  - On each pop with expect_valid=0: load expect = out_order+1 (mod 2^ORDW), set expect_valid=1.
  - On each pop with expect_valid=1: if out_order != expect, set order_err=1. Then expect = out_order+1 (mod 2^ORDW; 255 -> 0 wraps legally).
- Sticky flags clear only on reset.
- Flags never block the datapath.
- level never exceeds DEPTH.
- Full FIFO with out_ready=1 and k<=1 accepts the group.
- Empty FIFO with push: no output until the next cycle.

Test Plan:
- Single retire: NRET=2, ch1 valid only, order=5, pc_rdata=0x100, insn=0x00000013 -> next cycle out_valid=1, out_order=5, out_pc_rdata=0x100; after pop level=0, out_valid=0.
- Dual retire with compaction: ch0 order=7 and ch1 order=8 in one cycle, out_ready=1 -> out_order 7 then 8 on consecutive cycles; order_err stays 0.
- Backpressure and overflow: out_ready=0, push 4 dual groups (DEPTH=8) -> level=8, overflow=0. Fifth dual group -> dropped, level=8, overflow=1, head record unchanged.
- Full with simultaneous pop: level=8, out_ready=1, single retire -> accepted, level stays 8, overflow unchanged.
- Order gap and wrap: pops with order 254, 255, 0 -> order_err=0. A following pop with order 2 -> order_err=1.
- Reset mid-stream: level=5, resetn=0 for one cycle with rvfi_valid=2'b11 -> level=0, out_valid=0, flags 0. The next pop reloads expect without flagging.

Source files
------------

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: gathers per-cycle retirements from NRET RVFI
// channels into a circular FIFO and replays them one record per cycle, in
// channel order, on a single ready/valid stream. Flags dropped retire groups
// (overflow) and discontinuities in rvfi_order at the output (order_err).
module rvfi_retire_serializer #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned ORDW  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*ORDW-1:0]      rvfi_order,
  input  logic [NRET*ILEN-1:0]      rvfi_insn,
  input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
  input  logic [NRET-1:0]           rvfi_trap,
  input  logic [NRET-1:0]           rvfi_halt,
  input  logic [NRET-1:0]           rvfi_intr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDW-1:0]           out_order,
  output logic [ILEN-1:0]           out_insn,
  output logic [XLEN-1:0]           out_pc_rdata,
  output logic [XLEN-1:0]           out_pc_wdata,
  output logic                      out_trap,
  output logic                      out_halt,
  output logic                      out_intr,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      order_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = ORDW + ILEN + 2 * XLEN + 3;

  typedef logic [LW:0]   cnt_t;
  typedef logic [RW-1:0] rec_t;

  rec_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic            r_order_err;
  logic [ORDW-1:0] r_expect;
  logic            r_expect_valid;

  cnt_t            w_k;
  cnt_t            w_free;
  cnt_t            w_level_nxt;
  logic [AW-1:0]   w_off [NRET];
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  rec_t            w_head;

  // Count retiring channels and give each valid channel its compacted slot offset.
  always_comb begin
    w_k = '0;
    for (int unsigned c = 0; c < NRET; c++) begin
      w_off[c] = w_k[AW-1:0];
      if (rvfi_valid[c]) w_k = w_k + cnt_t'(1);
    end
  end

  // Space check: a same-cycle pop frees its slot before the group is admitted.
  always_comb begin
    w_pop       = out_valid && out_ready;
    w_free      = cnt_t'(DEPTH) - cnt_t'(r_level) + cnt_t'(w_pop);
    w_push      = resetn && (w_k != '0) && (w_k <= w_free);
    w_drop      = resetn && (w_k > w_free);
    w_level_nxt = cnt_t'(r_level) + (w_push ? w_k : '0) - cnt_t'(w_pop);
  end

  // Storage writes; no reset needed since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int unsigned c = 0; c < NRET; c++) begin
        if (rvfi_valid[c]) begin
          r_mem[r_wr_ptr + w_off[c]] <= {rvfi_order[c*ORDW +: ORDW],
                                         rvfi_insn[c*ILEN +: ILEN],
                                         rvfi_pc_rdata[c*XLEN +: XLEN],
                                         rvfi_pc_wdata[c*XLEN +: XLEN],
                                         rvfi_trap[c], rvfi_halt[c], rvfi_intr[c]};
        end
      end
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + w_k[AW-1:0];
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      r_level <= w_level_nxt[LW-1:0];
    end
  end

  // Order continuity checker on the output stream; first pop after reset only seeds it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_expect       <= '0;
      r_expect_valid <= 1'b0;
      r_order_err    <= 1'b0;
    end else if (w_pop) begin
      if (r_expect_valid && (out_order != r_expect)) r_order_err <= 1'b1;
      r_expect       <= out_order + 1'b1;
      r_expect_valid <= 1'b1;
    end
  end

  // Head of FIFO drives the output record directly.
  always_comb begin
    w_head       = r_mem[r_rd_ptr];
    out_valid    = (r_level != '0);
    {out_order, out_insn, out_pc_rdata, out_pc_wdata,
     out_trap, out_halt, out_intr} = w_head;
    level        = r_level;
    overflow     = r_overflow;
    order_err    = r_order_err;
  end

endmodule
